uart_tx_buffered: RTL
=====================

// Module: uart_tx_buffered
// PURPOSE
//  8N1 UART transmitter with a small write FIFO. It is the sending end of the link
//  served by the UART receiver (2604 clk/bit).
//  Host logic pushes bytes with a one-cycle strobe. The block serialises them
//  back-to-back on TX with no idle gap between queued frames.
//  It reports frame completion and FIFO status for flow control.
// PARAMETERS
//  BAUD_DIV  2604  clocks per bit; must match receiver (full bit 2604, half 1302); >=4
//  DEPTH     4     FIFO entries; power of 2, >=2
// PORTS
//  clk       in   1  system clock, all state on posedge
//  rst_n     in   1  asynchronous active-low reset
//  trmt      in   1  push strobe: tx_data written to FIFO when high and fifo_full low
//  tx_data   in   8  byte to send, sampled with trmt
//  TX        out  1  serial line, idle high
//  tx_done   out  1  one-cycle pulse after each frame's stop bit completes
//  fifo_full out  1  FIFO holds DEPTH entries; further trmt dropped
//  tx_busy   out  1  high while a frame is on the line or the FIFO is non-empty
// BEHAVIOUR
//  Reset (async): TX=1, tx_done=0, fifo_full=0, tx_busy=0, FIFO empty, state IDLE.
//   Reset mid-frame aborts the frame; TX returns high immediately; queued bytes lost.
//  FIFO: wr/rd pointers clog2(DEPTH) bits, wrap naturally; count clog2(DEPTH)+1 bits.
//   Write accepted iff trmt & ~fifo_full (registered flag). A pop in the same cycle
//   does not rescue a push while full: that byte is dropped and no state changes.
//   Simultaneous push+pop when not full: count unchanged, both pointers advance.
//  Shift reg 10 bits, loaded {1'b1,data,1'b0}; TX = shreg[0]; shifts right filling 1.
//  baud_cnt counts 0..BAUD_DIV-1; bit_cnt counts 0..9.
//  States:
//   IDLE: TX=1. If FIFO non-empty: pop, load shreg, baud_cnt=0, bit_cnt=0 -> XMIT.
//   XMIT: baud_cnt++. At baud_cnt==BAUD_DIV-1: baud_cnt=0, shift, bit_cnt++.
//    When bit_cnt==9 and baud_cnt==BAUD_DIV-1 (last stop cycle): tx_done=1 next cycle.
//     If FIFO non-empty: pop and reload same edge, stay XMIT (back-to-back frames).
//     Else: -> IDLE.
//  Latency: trmt sampled at edge k into an empty FIFO/IDLE -> pop at edge k+1;
//   TX low from edge k+1.
//  Each frame is exactly 10*BAUD_DIV cycles. Data is sent LSB first.
//  Outputs: tx_done is a registered one-cycle pulse, never two consecutive cycles.
//   tx_busy = (state==XMIT) | (count!=0), registered. fifo_full = (count==DEPTH).
//  tx_data is captured at push; later changes do not affect queued bytes.
// TESTING
//  1 Single byte, BAUD_DIV=2604: trmt 1 cycle, tx_data=8'hA5. Required:
//    TX low at k+1 for 2604 clk, then bits 1,0,1,0,0,1,0,1 at 2604 clk each, stop high.
//    tx_done pulses once, 26040 clk after TX fell.
//    Loopback into the UART receiver gives cmd=8'hA5, rdy=1.
//  2 Burst, DEPTH=4, BAUD_DIV=4: six consecutive trmt cycles with data 8'h10..8'h15.
//    Required: fifo_full high after the 5th push; 8'h15 dropped.
//    TX carries 10,11,12,13,14 back-to-back in 200 clk; exactly 5 tx_done pulses.
//    tx_busy falls the cycle after the last tx_done.
//  3 Push during frame: send 8'h3C, push 8'hC3 mid-start-bit. Required: 8'hC3 start bit
//    begins the cycle right after 8'h3C stop bit ends (no idle gap); 2 tx_done pulses.
//  4 Reset mid-frame: assert rst_n low during data bit 4 with 2 bytes queued.
//    Required: TX=1, tx_busy=0, fifo_full=0 immediately.
//    After release, TX stays high with no tx_done until a new trmt.
//  5 Wrap: BAUD_DIV=4, stream 12 bytes 8'h00..8'h0B paced by tx_done. Pointers wrap
//    three times. Required: receiver gets all 12 in order; fifo_full never asserts.
//  6 Idle stability: no trmt for 50000 clk after reset. Required: TX=1, tx_done=0,
//    tx_busy=0 throughout.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small write FIFO; queued bytes go out back-to-back.
// State | meaning: IDLE = line high, waiting for FIFO data; XMIT = frame on the line.
module uart_tx_buffered #(
  parameter int BAUD_DIV = 2604,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       fifo_full,
  output logic       tx_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;
  logic [9:0]    shreg, shreg_nxt, frame_load;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic          done_nxt, baud_tc, fifo_nempty;

  assign fifo_full   = (count == FULL_CNT);
  assign fifo_nempty = (count != '0);
  assign push        = trmt & ~fifo_full;
  assign baud_tc     = (baud_cnt == BAUD_LAST);
  assign frame_load  = {1'b1, mem[rd_ptr], 1'b0};
  assign TX          = shreg[0];

  // FIFO storage needs no reset; occupancy is governed by count and pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nempty) begin
          pop       = 1'b1;
          shreg_nxt = frame_load;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = XMIT;
        end
      end
      XMIT: begin
        if (!baud_tc) begin
          baud_nxt = baud_cnt + 1'b1;
        end else if (bit_cnt == 4'd9) begin
          // last stop-bit cycle: chain straight into the next queued byte if any
          done_nxt = 1'b1;
          baud_nxt = '0;
          bit_nxt  = '0;
          if (fifo_nempty) begin
            pop       = 1'b1;
            shreg_nxt = frame_load;
          end else begin
            shreg_nxt = {1'b1, shreg[9:1]};
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt  = '0;
          shreg_nxt = {1'b1, shreg[9:1]};
          bit_nxt   = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_done  <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_done  <= done_nxt;
      tx_busy  <= (state == XMIT) | fifo_nempty;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
